// File: rtl/cache_fill_fsm.sv
// D-cache miss fill controller: fetches one 16-byte block as eight word
// reads, strobes each returned word into the data array, then the tag.
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [IDX_W-1:0]  word_index,
  output logic              write_tag_array
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [IDX_W:0]   REQ_END  = (IDX_W+1)'(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W:0]    req_cnt_q, req_cnt_d;
  logic [IDX_W-1:0]  rcv_cnt_q, rcv_cnt_d;

  logic             in_fill;
  logic             req_pend;
  logic             rx;
  logic             last_rx;
  logic [IDX_W-1:0] slot;

  assign in_fill  = (state_q == FILL);
  assign req_pend = in_fill && (req_cnt_q < REQ_END);
  assign rx       = in_fill && memory_data_valid;
  assign last_rx  = rx && (rcv_cnt_q == LAST_IDX);

  // Offset stays inside the aligned block, so OR-ing never carries upward.
  assign slot = req_pend ? req_cnt_q[IDX_W-1:0] : LAST_IDX;

  assign fsm_busy         = !rst && (in_fill || miss_detected);
  assign mem_read_en      = req_pend;
  assign memory_address   = in_fill ?
    (base_q | {{(ADDR_W-IDX_W-1){1'b0}}, slot, 1'b0}) : '0;
  assign write_data_array = rx;
  assign word_index       = in_fill ? rcv_cnt_q : '0;
  assign write_tag_array  = last_rx;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    req_cnt_d = req_cnt_q;
    rcv_cnt_d = rcv_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d    = {miss_address[ADDR_W-1:IDX_W+1], {(IDX_W+1){1'b0}}};
          req_cnt_d = '0;
          rcv_cnt_d = '0;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (req_pend) req_cnt_d = req_cnt_q + 1'b1;
        if (rx)       rcv_cnt_d = rcv_cnt_q + 1'b1;
        if (last_rx)  state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      req_cnt_q <= req_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: one task per scenario, outputs
// compared as a packed bundle one time unit after each falling edge.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic        write_tag_array;

  int checks = 0;
  int errors = 0;

  cache_fill_fsm #(.ADDR_W(16), .WORDS(8), .IDX_W(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  // {busy, rd_en, addr[15:0], wr_data, idx[2:0], wr_tag}
  logic [22:0] obs;
  assign obs = {fsm_busy, mem_read_en, memory_address,
                write_data_array, word_index, write_tag_array};

  // Expected bundle for a fill started at cycle 0 with memory latency 4.
  function automatic logic [22:0] exp_fill(int c, logic [15:0] base);
    logic        b, r, w, t;
    logic [15:0] a;
    logic [2:0]  x;
    b = (c <= 12);
    r = (c >= 1 && c <= 8);
    a = r ? base + 16'(2 * (c - 1)) : (c >= 9 && c <= 12) ? base + 16'd14 : 16'd0;
    w = (c >= 5 && c <= 12);
    x = w ? 3'(c - 5) : 3'd0;
    t = (c == 12);
    return {b, r, a, w, x, t};
  endfunction

  task automatic idle_inputs();
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (obs !== 23'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, 23'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_fill();
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      miss_detected     = (c == 0);
      miss_address      = 16'h1234;
      memory_data_valid = (c >= 5 && c <= 12);
      #1;
      checks++;
      if (obs !== exp_fill(c, 16'h1230)) begin
        errors++;
        $display("FAIL basic c%0d: got %h want %h", c, obs, exp_fill(c, 16'h1230));
      end
    end
    idle_inputs();
  endtask

  task automatic test_top_of_memory();
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      miss_detected     = (c == 0);
      miss_address      = 16'hFFFF;
      memory_data_valid = (c >= 5 && c <= 12);
      #1;
      checks++;
      if (obs !== exp_fill(c, 16'hFFF0)) begin
        errors++;
        $display("FAIL top c%0d: got %h want %h", c, obs, exp_fill(c, 16'hFFF0));
      end
      if (c == 8) begin
        checks++;
        if (memory_address !== 16'hFFFE) begin
          errors++;
          $display("FAIL top_last_req: got %h want fffe", memory_address);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_miss_while_busy();
    int tags = 0;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      miss_detected     = (c == 0 || c == 6);
      miss_address      = (c == 0) ? 16'h1230 : 16'h4000;
      memory_data_valid = (c >= 5 && c <= 12);
      #1;
      if (write_tag_array === 1'b1) tags++;
      checks++;
      if (obs !== exp_fill(c, 16'h1230)) begin
        errors++;
        $display("FAIL busy_miss c%0d: got %h want %h", c, obs, exp_fill(c, 16'h1230));
      end
    end
    checks++;
    if (tags != 1) begin
      errors++;
      $display("FAIL busy_miss_tags: got %0d want 1", tags);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_fill();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      miss_detected     = (c == 0);
      miss_address      = 16'h1230;
      memory_data_valid = (c >= 5);
      #1;
      checks++;
      if (obs !== exp_fill(c, 16'h1230)) begin
        errors++;
        $display("FAIL pre_rst c%0d: got %h want %h", c, obs, exp_fill(c, 16'h1230));
      end
    end
    @(negedge clk);
    rst = 1'b1;
    miss_detected = 1'b0;
    memory_data_valid = 1'b1;
    #1;
    checks++;
    if (obs !== 23'd0) begin
      errors++;
      $display("FAIL rst_mid: got %h want %h", obs, 23'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      memory_data_valid = c[0];
      #1;
      checks++;
      if (obs !== 23'd0) begin
        errors++;
        $display("FAIL stale_valid c%0d: got %h want %h", c, obs, 23'd0);
      end
    end
    idle_inputs();
  endtask

  task automatic test_gapped();
    int n = 0;
    logic v;
    logic [22:0] e;
    logic [15:0] a;
    for (int c = 0; c <= 21; c++) begin
      @(negedge clk);
      v = (c == 5 || c == 7 || c == 8 || c == 11 || c == 12 ||
           c == 15 || c == 16 || c == 20);
      miss_detected     = (c == 0);
      miss_address      = 16'h1234;
      memory_data_valid = v;
      #1;
      a = (c >= 1 && c <= 8) ? 16'h1230 + 16'(2 * (c - 1)) :
          (c >= 9 && c <= 20) ? 16'h123E : 16'h0000;
      e = {(c <= 20), (c >= 1 && c <= 8), a,
           (v && c <= 20), (c <= 20) ? 3'(n) : 3'd0, (c == 20)};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL gapped c%0d: got %h want %h", c, obs, e);
      end
      if (v) n++;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic v, r, w, t;
    logic [15:0] a;
    logic [2:0]  x;
    logic [22:0] e;
    for (int c = 0; c <= 26; c++) begin
      @(negedge clk);
      v = (c >= 5 && c <= 12) || (c >= 18 && c <= 25);
      miss_detected     = (c == 0 || c == 12 || c == 13);
      miss_address      = (c == 0) ? 16'h1234 : 16'h2008;
      memory_data_valid = v;
      #1;
      r = (c >= 1 && c <= 8) || (c >= 14 && c <= 21);
      a = (c >= 1 && c <= 8)   ? 16'h1230 + 16'(2 * (c - 1)) :
          (c >= 9 && c <= 12)  ? 16'h123E :
          (c >= 14 && c <= 21) ? 16'h2000 + 16'(2 * (c - 14)) :
          (c >= 22 && c <= 25) ? 16'h200E : 16'h0000;
      w = v;
      x = (c >= 5 && c <= 12) ? 3'(c - 5) :
          (c >= 18 && c <= 25) ? 3'(c - 18) : 3'd0;
      t = (c == 12 || c == 25);
      e = {(c <= 25), r, a, w, x, t};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL b2b c%0d: got %h want %h", c, obs, e);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_fill();
    test_top_of_memory();
    test_miss_while_busy();
    test_reset_mid_fill();
    test_gapped();
    test_back_to_back();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
